// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator layer-memory path:
// memory select codes, default bus widths and the port-arbiter state encoding.
package cnn_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 20;
    localparam int SELW_DEF = 3;

    typedef enum logic [2:0] {
        CSEL_NONE = 3'd0,
        L0_K0     = 3'd1,
        L0_K1     = 3'd2,
        L1_K0     = 3'd3,
        L1_K1     = 3'd4,
        L2        = 3'd5
    } csel_e;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = PW'(k);
            end
        end
    end

endmodule

// File: rtl/lmem_port_arbiter.sv
// Shares the single layer-memory port between NREQ engines: round-robin grants with
// optional locked bursts, registered memory commands and a one-hot read-return path.
module lmem_port_arbiter
    import cnn_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int SELW     = SELW_DEF,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*SELW-1:0] sel,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 cwr,
    output logic                 crd,
    output logic [SELW-1:0]      csel,
    output logic [AW-1:0]        caddr_wr,
    output logic [DW-1:0]        cdata_wr,
    output logic [AW-1:0]        caddr_rd,
    input  logic [DW-1:0]        cdata_rd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    logic            accept;
    logic [PW-1:0]   acc_idx;
    logic [PW-1:0]   acc_next;

    logic            rd_p1;
    logic [PW-1:0]   id_p1;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grants are held off entirely while reset is low so nothing is accepted then.
    always_comb begin
        gnt = '0;
        if (reset) begin
            if (state == ARB)
                gnt = pick_onehot;
            else
                gnt[owner] = req[owner];
        end
    end

    assign accept   = |(req & gnt);
    assign acc_idx  = (state == OWN) ? owner : pick_idx;
    assign acc_next = (int'(acc_idx) == NREQ - 1) ? '0 : acc_idx + PW'(1);
    assign rdata    = cdata_rd;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (pick_any) begin
                        ptr <= acc_next;
                        if (lock[pick_idx] && LOCK_MAX > 1) begin
                            owner <= pick_idx;
                            cnt   <= CW'(1);
                            state <= OWN;
                        end
                    end
                end
                OWN: begin
                    // ptr already points past the owner, so it loses priority on exit.
                    if (req[owner]) begin
                        cnt <= cnt + CW'(1);
                        if (!lock[owner] || (cnt + CW'(1) == CW'(LOCK_MAX)))
                            state <= ARB;
                    end else begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            caddr_rd <= '0;
            rd_p1    <= 1'b0;
            id_p1    <= '0;
            rvalid   <= '0;
        end else begin
            cwr   <= accept &&  we[acc_idx];
            crd   <= accept && !we[acc_idx];
            rd_p1 <= accept && !we[acc_idx];
            if (accept) begin
                csel  <= sel[acc_idx*SELW +: SELW];
                id_p1 <= acc_idx;
                if (we[acc_idx]) begin
                    caddr_wr <= addr[acc_idx*AW +: AW];
                    cdata_wr <= wdata[acc_idx*DW +: DW];
                end else begin
                    caddr_rd <= addr[acc_idx*AW +: AW];
                end
            end
            // Memory returns data one cycle after crd; flag the requester in that cycle.
            rvalid <= rd_p1 ? (NREQ'(1) << id_p1) : '0;
        end
    end

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Directed bench for lmem_port_arbiter with a registered memory model on the command port.
module tb_lmem_port_arbiter;
    import cnn_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;
    localparam int SELW = 3;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      we;
    logic [NREQ*SELW-1:0] sel;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 cwr;
    logic                 crd;
    logic [SELW-1:0]      csel;
    logic [AW-1:0]        caddr_wr;
    logic [DW-1:0]        cdata_wr;
    logic [AW-1:0]        caddr_rd;
    logic [DW-1:0]        cdata_rd;

    int vectors;
    int miscompares;

    logic [DW-1:0] mem [0:7][0:4095];

    lmem_port_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .SELW     (SELW),
        .LOCK_MAX (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .sel      (sel),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .cwr      (cwr),
        .crd      (crd),
        .csel     (csel),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Layer memory: write on cwr, read data registered one cycle after crd.
    always @(posedge clk) begin
        if (cwr) mem[csel][caddr_wr] <= cdata_wr;
        if (crd) cdata_rd <= mem[csel][caddr_rd];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic w, input logic [SELW-1:0] s,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]              = w;
        sel[i*SELW +: SELW] = s;
        addr[i*AW +: AW]    = a;
        wdata[i*DW +: DW]   = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},      32'(gnt),      32'h0);
        check({tag, "_cwr"},      32'(cwr),      32'h0);
        check({tag, "_crd"},      32'(crd),      32'h0);
        check({tag, "_csel"},     32'(csel),     32'h0);
        check({tag, "_caddr_wr"}, 32'(caddr_wr), 32'h0);
        check({tag, "_cdata_wr"}, 32'(cdata_wr), 32'h0);
        check({tag, "_caddr_rd"}, 32'(caddr_rd), 32'h0);
        check({tag, "_rvalid"},   32'(rvalid),   32'h0);
    endtask

    logic [NREQ-1:0] rr_order [0:5];
    logic [NREQ-1:0] lk_order [0:5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        cdata_rd    = '0;
        mem[3][12'h041] = 20'h0ABCD;
        rr_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        lk_order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

        reset = 1'b0;
        req   = '1;
        lock  = '0;
        we    = '0;
        sel   = '0;
        addr  = '0;
        wdata = '0;

        // Reset state, with requests pending: no grant may appear.
        #1;
        check_idle_outputs("reset");
        #2;
        reset = 1'b1;
        req   = '0;

        // 1: single read by requester 1 from L1_K0.
        req = 3'b010;
        set_port(1, 1'b0, L1_K0, 12'h041, '0);
        #1;
        check("t1_gnt", 32'(gnt), 32'h2);
        tick();
        req = '0;
        check("t1_crd",      32'(crd),      32'h1);
        check("t1_cwr",      32'(cwr),      32'h0);
        check("t1_csel",     32'(csel),     32'h3);
        check("t1_caddr_rd", 32'(caddr_rd), 32'h041);
        check("t1_rvalid0",  32'(rvalid),   32'h0);
        tick();
        check("t1_rvalid",   32'(rvalid),   32'h2);
        check("t1_rdata",    32'(rdata),    32'h0ABCD);
        check("t1_crd_off",  32'(crd),      32'h0);

        // 2: all three requesting from a fresh reset -> strict rotation.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req = 3'b111;
        for (int i = 0; i < NREQ; i++) set_port(i, 1'b1, CSEL_NONE, 12'(i), 20'(i));
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(rr_order[i]));
            tick();
            check($sformatf("t2_cwr%0d", i), 32'(cwr), 32'h1);
        end
        check("t2_last_addr", 32'(caddr_wr), 32'h2);
        req = '0;

        // 3: requester 0 locked against requester 1 -> four in a row, then 1, then 0.
        req  = 3'b011;
        lock = 3'b001;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t3_gnt%0d", i), 32'(gnt), 32'(lk_order[i]));
            tick();
        end
        req  = '0;
        lock = '0;
        #1;
        check("t3_release_gnt", 32'(gnt), 32'h0);
        tick();

        // 4: write then read of L2 address 7 by requester 2 in consecutive cycles.
        req = 3'b100;
        set_port(2, 1'b1, L2, 12'h007, 20'h12345);
        #1;
        check("t4_wr_gnt", 32'(gnt), 32'h4);
        tick();
        check("t4_cwr",      32'(cwr),      32'h1);
        check("t4_csel_w",   32'(csel),     32'h5);
        check("t4_caddr_wr", 32'(caddr_wr), 32'h007);
        check("t4_cdata_wr", 32'(cdata_wr), 32'h12345);
        set_port(2, 1'b0, L2, 12'h007, '0);
        #1;
        check("t4_rd_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        check("t4_crd",      32'(crd),      32'h1);
        check("t4_cwr_off",  32'(cwr),      32'h0);
        check("t4_caddr_rd", 32'(caddr_rd), 32'h007);
        tick();
        check("t4_rvalid", 32'(rvalid), 32'h4);
        check("t4_rdata",  32'(rdata),  32'h12345);

        // 5: locked owner drops its request -> one idle cycle, then requester 1.
        req  = 3'b011;
        lock = 3'b001;
        set_port(0, 1'b1, L0_K0, 12'h100, 20'h00011);
        set_port(1, 1'b1, L0_K1, 12'h200, 20'h00022);
        #1;
        check("t5_own_gnt", 32'(gnt), 32'h1);
        tick();
        req = 3'b010;
        #1;
        check("t5_gap_gnt", 32'(gnt), 32'h0);
        tick();
        check("t5_gap_cwr", 32'(cwr), 32'h0);
        #1;
        check("t5_next_gnt", 32'(gnt), 32'h2);
        tick();
        check("t5_next_csel", 32'(csel), 32'h2);
        req  = '0;
        lock = '0;

        // 6: reset between accept and rvalid drops the read and restarts priority at 0.
        req = 3'b001;
        set_port(0, 1'b0, L0_K0, 12'h010, '0);
        #1;
        check("t6_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        check("t6_crd", 32'(crd), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        req = 3'b111;
        #1;
        check_idle_outputs("t6_rst");
        reset = 1'b1;
        req   = '0;
        tick();
        check("t6_rvalid_a", 32'(rvalid), 32'h0);
        check("t6_crd_a",    32'(crd),    32'h0);
        tick();
        check("t6_rvalid_b", 32'(rvalid), 32'h0);
        req = 3'b111;
        #1;
        check("t6_first_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
